// File: rtl/softreg_seq.sv
// softreg_seq: replays a loadable table of SoftReg commands on start.
// Define SOFTREG_SEQ_POLL_EN to re-issue polled reads until non-zero.
module softreg_seq #(
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int GAP     = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_valid,
    input  logic [$clog2(DEPTH)-1:0]   load_idx,
    input  logic                       load_isWrite,
    input  logic                       load_isPoll,
    input  logic [ADDR_W-1:0]          load_addr,
    input  logic [DATA_W-1:0]          load_data,
    input  logic [$clog2(DEPTH+1)-1:0] num_cmds,
    input  logic                       start,
    output logic                       softreg_req_valid,
    output logic                       softreg_req_isWrite,
    output logic [ADDR_W-1:0]          softreg_req_addr,
    output logic [DATA_W-1:0]          softreg_req_data,
    input  logic                       softreg_resp_valid,
    input  logic [DATA_W-1:0]          softreg_resp_data,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [DATA_W-1:0]          last_resp_data
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int GW = $clog2(GAP + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] N_MAX  = CW'(DEPTH);
    localparam logic [GW-1:0] G_LAST = GW'(GAP - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_GAP, S_DONE
    } state_t;

    state_t state, state_d;
    logic [CW-1:0] ptr, ptr_d;
    logic [CW-1:0] n, n_d;
    logic [GW-1:0] gcnt, gcnt_d;
    logic [TW-1:0] tcnt, tcnt_d;
    logic error_d;
    logic [DATA_W-1:0] lrd_d;

    logic tbl_wr [DEPTH];
    logic [ADDR_W-1:0] tbl_addr [DEPTH];
    logic [DATA_W-1:0] tbl_data [DEPTH];

    logic [IW-1:0] idx;
    logic idle, load_en, cur_wr, cur_poll;

    assign idle    = (state == S_IDLE);
    assign load_en = idle && load_valid;
    assign idx     = ptr[IW-1:0];
    assign cur_wr  = tbl_wr[idx];

    // Table holds no reset; it is only written while idle.
    always_ff @(posedge clk) begin
        if (load_en) begin
            tbl_wr[load_idx]   <= load_isWrite;
            tbl_addr[load_idx] <= load_addr;
            tbl_data[load_idx] <= load_data;
        end
    end

`ifdef SOFTREG_SEQ_POLL_EN
    logic tbl_poll [DEPTH];

    always_ff @(posedge clk) begin
        if (load_en) begin
            tbl_poll[load_idx] <= load_isPoll;
        end
    end

    assign cur_poll = tbl_poll[idx];
`else
    logic unused_poll;

    assign unused_poll = load_isPoll;
    assign cur_poll    = 1'b0;
`endif

    always_comb begin
        state_d             = state;
        ptr_d               = ptr;
        n_d                 = n;
        gcnt_d              = gcnt;
        tcnt_d              = tcnt;
        error_d             = error;
        lrd_d               = last_resp_data;
        softreg_req_valid   = 1'b0;
        softreg_req_isWrite = 1'b0;
        softreg_req_addr    = '0;
        softreg_req_data    = '0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    n_d     = (num_cmds > N_MAX) ? N_MAX : num_cmds;
                    error_d = 1'b0;
                    ptr_d   = '0;
                    state_d = (num_cmds == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                softreg_req_valid   = 1'b1;
                softreg_req_isWrite = cur_wr;
                softreg_req_addr    = tbl_addr[idx];
                softreg_req_data    = tbl_data[idx];
                gcnt_d              = '0;
                tcnt_d              = '0;
                if (cur_wr) begin
                    ptr_d   = ptr + 1'b1;
                    state_d = S_GAP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A response on the last allowed cycle beats the timeout.
                if (softreg_resp_valid) begin
                    lrd_d   = softreg_resp_data;
                    state_d = S_GAP;
                    if (!(cur_poll && softreg_resp_data == '0)) begin
                        ptr_d = ptr + 1'b1;
                    end
                end else if (tcnt == T_LAST) begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tcnt_d = tcnt + 1'b1;
                end
            end
            S_GAP: begin
                if (gcnt == G_LAST) begin
                    state_d = (ptr < n) ? S_ISSUE : S_DONE;
                end else begin
                    gcnt_d = gcnt + 1'b1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            ptr            <= '0;
            n              <= '0;
            gcnt           <= '0;
            tcnt           <= '0;
            error          <= 1'b0;
            last_resp_data <= '0;
        end else begin
            state          <= state_d;
            ptr            <= ptr_d;
            n              <= n_d;
            gcnt           <= gcnt_d;
            tcnt           <= tcnt_d;
            error          <= error_d;
            last_resp_data <= lrd_d;
        end
    end

    assign busy = !idle;
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_softreg_seq.sv
// tb_softreg_seq: scoreboard bench for softreg_seq with a timeline model.
// Expected strobes/done are predicted per run; a monitor pops and compares.
module tb_softreg_seq;
    localparam int DEPTH = 16;
    localparam int AW    = 32;
    localparam int DW    = 64;
    localparam int GAP   = 2;
    localparam int TMO   = 16;
`ifdef SOFTREG_SEQ_POLL_EN
    localparam bit POLL = 1'b1;
`else
    localparam bit POLL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic load_valid = 1'b0;
    logic [3:0] load_idx = '0;
    logic load_isWrite = 1'b0;
    logic load_isPoll = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [DW-1:0] load_data = '0;
    logic [4:0] num_cmds = '0;
    logic start = 1'b0;
    logic req_valid, req_isWrite;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic resp_valid = 1'b0;
    logic [DW-1:0] resp_data = '0;
    logic busy, done, error;
    logic [DW-1:0] last_resp_data;

    always #5 clk = ~clk;

    softreg_seq #(
        .DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW),
        .GAP(GAP), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_idx(load_idx),
        .load_isWrite(load_isWrite), .load_isPoll(load_isPoll),
        .load_addr(load_addr), .load_data(load_data),
        .num_cmds(num_cmds), .start(start),
        .softreg_req_valid(req_valid),
        .softreg_req_isWrite(req_isWrite),
        .softreg_req_addr(req_addr),
        .softreg_req_data(req_data),
        .softreg_resp_valid(resp_valid),
        .softreg_resp_data(resp_data),
        .busy(busy), .done(done), .error(error),
        .last_resp_data(last_resp_data)
    );

    typedef struct {
        int cyc; logic w; logic [AW-1:0] a; logic [DW-1:0] d;
    } req_t;
    typedef struct {
        int cyc; logic err; logic [DW-1:0] lrd;
    } done_t;
    typedef struct {
        int dly; logic [DW-1:0] d;
    } rsp_t;

    req_t  req_q[$];
    done_t done_q[$];
    rsp_t  rsp_q[$];
    rsp_t  dir_q[$];

    logic          m_w [DEPTH];
    logic          m_p [DEPTH];
    logic [AW-1:0] m_a [DEPTH];
    logic [DW-1:0] m_d [DEPTH];
    logic [DW-1:0] m_lrd = '0;

    int vectors = 0;
    int misc = 0;
    int cyc = 0;
    int done_seen = 0;
    int exp_done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Read responder: dly cycles after the strobe, or never if dly==0.
    always begin
        rsp_t r;
        @(negedge clk);
        if (rst && req_valid && !req_isWrite && rsp_q.size() > 0) begin
            r = rsp_q.pop_front();
            if (r.dly != 0) begin
                repeat (r.dly) @(posedge clk);
                #1 resp_valid = 1'b1;
                resp_data = r.d;
                @(posedge clk);
                #1 resp_valid = 1'b0;
                resp_data = '0;
            end
        end
    end

    // Monitor: pops one expectation per observed strobe or done.
    always @(negedge clk) begin
        req_t e;
        done_t f;
        if (rst) begin
            if (req_valid) begin
                vectors++;
                if (req_q.size() == 0) begin
                    misc++;
                    $display("FAIL req_extra cyc=%0d addr=%h", cyc, req_addr);
                end else begin
                    e = req_q.pop_front();
                    if (e.cyc != cyc || e.w !== req_isWrite ||
                        e.a !== req_addr || e.d !== req_data) begin
                        misc++;
                        $display("FAIL req got cyc=%0d w=%b a=%h d=%h want cyc=%0d w=%b a=%h d=%h",
                                 cyc, req_isWrite, req_addr, req_data,
                                 e.cyc, e.w, e.a, e.d);
                    end
                end
            end else begin
                vectors++;
                if (req_isWrite !== 1'b0 || req_addr !== '0 ||
                    req_data !== '0) begin
                    misc++;
                    $display("FAIL req_idle cyc=%0d got a=%h want 0",
                             cyc, req_addr);
                end
            end
            if (done) begin
                done_seen++;
                vectors++;
                if (done_q.size() == 0) begin
                    misc++;
                    $display("FAIL done_extra cyc=%0d", cyc);
                end else begin
                    f = done_q.pop_front();
                    if (f.cyc != cyc || f.err !== error ||
                        f.lrd !== last_resp_data) begin
                        misc++;
                        $display("FAIL done got cyc=%0d err=%b lrd=%h want cyc=%0d err=%b lrd=%h",
                                 cyc, error, last_resp_data,
                                 f.cyc, f.err, f.lrd);
                    end
                end
            end
        end
    end

    function automatic rsp_t next_rsp(logic poll, int zeros);
        rsp_t r;
        if (dir_q.size() > 0) return dir_q.pop_front();
        r.dly = ($urandom_range(0, 11) == 0) ? 0 : $urandom_range(1, TMO);
        if ((poll && zeros >= 3) || $urandom_range(0, 3) != 0)
            r.d = {$urandom(), $urandom()} | 64'h1;
        else
            r.d = '0;
        return r;
    endfunction

    // Timeline of one run, from start accepted at cycle t.
    task automatic predict(int t, int num);
        int n, p, tt, zeros;
        rsp_t r;
        req_t e;
        done_t f;
        n = (num > DEPTH) ? DEPTH : num;
        tt = t + 1;
        p = 0;
        zeros = 0;
        exp_done++;
        while (p < n) begin
            e.cyc = tt; e.w = m_w[p]; e.a = m_a[p]; e.d = m_d[p];
            req_q.push_back(e);
            if (m_w[p]) begin
                tt += GAP + 1;
                p++;
            end else begin
                r = next_rsp(m_p[p], zeros);
                rsp_q.push_back(r);
                if (r.dly == 0) begin
                    f.cyc = tt + TMO + 1; f.err = 1'b1; f.lrd = m_lrd;
                    done_q.push_back(f);
                    dir_q.delete();
                    return;
                end
                m_lrd = r.d;
                if (POLL && m_p[p] && r.d == '0) zeros++;
                else begin
                    p++;
                    zeros = 0;
                end
                tt += r.dly + GAP + 1;
            end
        end
        f.cyc = tt; f.err = 1'b0; f.lrd = m_lrd;
        done_q.push_back(f);
        dir_q.delete();
    endtask

    task automatic drive_load(int i, logic w, logic p,
                              logic [AW-1:0] a, logic [DW-1:0] d);
        load_valid = 1'b1;
        load_idx = 4'(i);
        load_isWrite = w;
        load_isPoll = p;
        load_addr = a;
        load_data = d;
    endtask

    task automatic load_slot(int i, logic w, logic p,
                             logic [AW-1:0] a, logic [DW-1:0] d);
        drive_load(i, w, p, a, d);
        m_w[i] = w; m_p[i] = p; m_a[i] = a; m_d[i] = d;
        @(posedge clk);
        #1 load_valid = 1'b0;
    endtask

    task automatic start_seq(int num);
        predict(cyc, num);
        num_cmds = 5'(num);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        load_valid = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (done_seen < exp_done && k < 3000) begin
            @(posedge clk);
            k++;
        end
        #1;
        vectors++;
        if (done_seen < exp_done) begin
            misc++;
            $display("FAIL done_wait got %0d want %0d", done_seen, exp_done);
            exp_done = done_seen;
        end
        vectors++;
        if (busy !== 1'b0 || req_q.size() != 0 || done_q.size() != 0) begin
            misc++;
            $display("FAIL end_state got busy=%b reqs_left=%0d want 0",
                     busy, req_q.size());
            req_q.delete();
            done_q.delete();
        end
        rsp_q.delete();
    endtask

    task automatic check_zero(string name);
        vectors++;
        if ({req_valid, req_isWrite, busy, done, error} !== 5'b0 ||
            req_addr !== '0 || req_data !== '0 ||
            last_resp_data !== '0) begin
            misc++;
            $display("FAIL %s got busy=%b done=%b err=%b lrd=%h want 0",
                     name, busy, done, error, last_resp_data);
        end
    endtask

    initial begin
        int k, ds;
        rsp_t r;
        repeat (2) @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 check_zero("post_reset");

        // Five writes, GAP+1 apart.
        load_slot(0, 1, 0, 32'h00, 64'd0);
        load_slot(1, 1, 0, 32'h08, 64'd4);
        load_slot(2, 1, 0, 32'h28, 64'd256);
        load_slot(3, 1, 0, 32'h30, 64'h200);
        load_slot(4, 1, 0, 32'h10, 64'd4);
        start_seq(5);
        wait_done();

        // Single read, loaded in the same cycle as start.
        r.dly = 5; r.d = 64'h1234;
        dir_q.push_back(r);
        drive_load(0, 0, 0, 32'h18, 64'd0);
        m_w[0] = 0; m_p[0] = 0; m_a[0] = 32'h18; m_d[0] = 64'd0;
        start_seq(1);
        wait_done();

        // Polled read answered 0, 0, 7.
        load_slot(0, 0, 1, 32'h18, 64'd0);
        r.dly = 2; r.d = 64'd0; dir_q.push_back(r);
        r.dly = 4; dir_q.push_back(r);
        r.dly = 3; r.d = 64'd7; dir_q.push_back(r);
        start_seq(1);
        wait_done();

        // Timeout, then a zero-length run clears error.
        load_slot(0, 0, 0, 32'h40, 64'd0);
        r.dly = 0; r.d = 64'd0; dir_q.push_back(r);
        start_seq(1);
        wait_done();
        start_seq(0);
        wait_done();

        // num_cmds above DEPTH runs the whole table.
        for (int i = 0; i < DEPTH; i++)
            load_slot(i, 1, 0, $urandom(), {$urandom(), $urandom()});
        start_seq(20);
        wait_done();

        // start and load pulsed while busy are ignored.
        start_seq(3);
        repeat (2) @(posedge clk);
        #1 drive_load(1, 1, 0, 32'hdead, 64'hbeef);
        num_cmds = 5'd1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        load_valid = 1'b0;
        wait_done();
        start_seq(3);
        wait_done();

        // Reset in the gap after the first write.
        start_seq(2);
        k = 0;
        while (req_q.size() == 2 && k < 20) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1 rst = 1'b0;
        #1 check_zero("mid_reset");
        req_q.delete();
        done_q.delete();
        rsp_q.delete();
        exp_done = done_seen;
        ds = done_seen;
        m_lrd = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (10) @(posedge clk);
        #1 check_zero("after_reset");
        vectors++;
        if (done_seen != ds) begin
            misc++;
            $display("FAIL reset_done got %0d want %0d", done_seen, ds);
        end

        // Randomized tables, commands and responder timing.
        for (int it = 0; it < 25; it++) begin
            k = $urandom_range(2, 6);
            for (int j = 0; j < k; j++)
                load_slot($urandom_range(0, DEPTH - 1),
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)),
                          $urandom(), {$urandom(), $urandom()});
            start_seq($urandom_range(0, 20));
            wait_done();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end
endmodule
